// File: rtl/riscv_mem_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_mem_responder_if                                               |
// | Core fetch/data ports, loader stream and status of the responder.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface riscv_mem_responder_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] InstrAdr;
    logic [31:0]           InstrData;
    logic [ADDR_WIDTH-1:0] memAdr;
    logic [31:0]           memwrData;
    logic                  memWE;
    logic [31:0]           memrdData;
    logic                  ld_valid;
    logic                  ld_ready;
    logic [31:0]           ld_data;
    logic                  ld_last;
    logic                  core_resetn;
    logic                  halted;
    logic [31:0]           tohost;
    logic                  ld_overflow;
    logic                  addr_err;

    modport master (
        output InstrAdr, memAdr, memwrData, memWE, ld_valid, ld_data, ld_last,
        input  InstrData, memrdData, ld_ready, core_resetn, halted, tohost,
               ld_overflow, addr_err
    );

    modport slave (
        input  InstrAdr, memAdr, memwrData, memWE, ld_valid, ld_data, ld_last,
        output InstrData, memrdData, ld_ready, core_resetn, halted, tohost,
               ld_overflow, addr_err
    );
endinterface
`default_nettype wire

// File: rtl/riscv_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_mem_responder                                                  |
// | Word memory for core fetch/data, stream loader and tohost halt.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module riscv_mem_responder #(
    parameter int          MEM_WORDS   = 1024,
    parameter int          ADDR_WIDTH  = 32,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
    parameter logic [31:0] NOP_INSN    = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            resetn,
    riscv_mem_responder_if.slave bus
);
    localparam int                    c_IDX_W     = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] c_MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * 4);
    localparam logic [ADDR_WIDTH-1:0] c_TOHOST    = ADDR_WIDTH'(TOHOST_ADDR);
    localparam logic [c_IDX_W:0]      c_PTR_ONE   = (c_IDX_W + 1)'(1);

    localparam logic [1:0] c_ST_LOAD = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_HALT = 2'd2;

    logic [1:0]         r_state;
    logic [c_IDX_W:0]   r_ld_ptr;
    logic               r_ld_arm;
    logic               r_core_resetn;
    logic               r_halted;
    logic [31:0]        r_tohost;
    logic               r_ld_overflow;
    logic               r_addr_err;
    logic [31:0]        r_mem [MEM_WORDS];

    logic [1:0]         w_state_nxt;
    logic [c_IDX_W:0]   w_ld_ptr_nxt;
    logic               w_mem_we;
    logic [c_IDX_W-1:0] w_mem_idx;
    logic [31:0]        w_mem_wdata;
    logic               w_tohost_we;
    logic               w_set_ovf;
    logic               w_set_err;

    logic               w_i_in_range;
    logic               w_d_in_range;
    logic               w_d_tohost;
    logic [c_IDX_W-1:0] w_i_idx;
    logic [c_IDX_W-1:0] w_d_idx;
    logic               w_ld_hs;

    assign w_i_in_range = (bus.InstrAdr < c_MEM_BYTES);
    assign w_d_in_range = (bus.memAdr < c_MEM_BYTES);
    assign w_d_tohost   = (bus.memAdr == c_TOHOST);
    assign w_i_idx      = bus.InstrAdr[c_IDX_W+1:2];
    assign w_d_idx      = bus.memAdr[c_IDX_W+1:2];
    assign w_ld_hs      = (r_state == c_ST_LOAD) && r_ld_arm && bus.ld_valid;

    always_comb begin
        w_state_nxt  = r_state;
        w_ld_ptr_nxt = r_ld_ptr;
        w_mem_we     = 1'b0;
        w_mem_idx    = w_d_idx;
        w_mem_wdata  = bus.memwrData;
        w_tohost_we  = 1'b0;
        w_set_ovf    = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            c_ST_LOAD: begin
                if (w_ld_hs) begin
                    // Pointer top bit set means the array is full: drop the word.
                    if (!r_ld_ptr[c_IDX_W]) begin
                        w_mem_we     = 1'b1;
                        w_mem_idx    = r_ld_ptr[c_IDX_W-1:0];
                        w_mem_wdata  = bus.ld_data;
                        w_ld_ptr_nxt = r_ld_ptr + c_PTR_ONE;
                    end else begin
                        w_set_ovf = 1'b1;
                    end
                    if (bus.ld_last) begin
                        w_state_nxt = c_ST_RUN;
                    end
                end
            end
            c_ST_RUN: begin
                if (bus.memWE && w_d_in_range) begin
                    w_mem_we = 1'b1;
                end else if (bus.memWE && w_d_tohost) begin
                    w_tohost_we = 1'b1;
                    w_state_nxt = c_ST_HALT;
                end
                if (!w_d_in_range && !w_d_tohost) begin
                    w_set_err = 1'b1;
                end
            end
            c_ST_HALT: begin
                w_state_nxt = c_ST_HALT;
            end
            default: begin
                w_state_nxt = c_ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= c_ST_LOAD;
            r_ld_ptr      <= '0;
            r_ld_arm      <= 1'b0;
            r_core_resetn <= 1'b0;
            r_halted      <= 1'b0;
            r_tohost      <= 32'h0;
            r_ld_overflow <= 1'b0;
            r_addr_err    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ld_ptr      <= w_ld_ptr_nxt;
            r_ld_arm      <= 1'b1;
            r_core_resetn <= (w_state_nxt != c_ST_LOAD);
            if (w_tohost_we) begin
                r_tohost <= bus.memwrData;
                r_halted <= 1'b1;
            end
            if (w_set_ovf) begin
                r_ld_overflow <= 1'b1;
            end
            if (w_set_err) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    // Array is deliberately not cleared by reset so a reloaded image can be partial.
    always_ff @(posedge clk) begin
        if (resetn && w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wdata;
        end
    end

    assign bus.InstrData   = (r_state == c_ST_LOAD) ? NOP_INSN :
                             (w_i_in_range ? r_mem[w_i_idx] : 32'h0);
    assign bus.memrdData   = w_d_in_range ? r_mem[w_d_idx] :
                             (w_d_tohost ? r_tohost : 32'h0);
    assign bus.ld_ready    = (r_state == c_ST_LOAD) && r_ld_arm;
    assign bus.core_resetn = r_core_resetn;
    assign bus.halted      = r_halted;
    assign bus.tohost      = r_tohost;
    assign bus.ld_overflow = r_ld_overflow;
    assign bus.addr_err    = r_addr_err;
endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_riscv_mem_responder                                               |
// | Randomized bench with a word-array reference model, two depths.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_riscv_mem_responder;
    localparam int          c_BIG   = 1024;
    localparam int          c_SMALL = 4;
    localparam logic [31:0] c_TOHOST = 32'h0000_1000;
    localparam logic [31:0] c_NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic resetn;
    logic resetn_s;
    int   vectors = 0;
    int   miscompares = 0;

    logic [31:0] model_mem [c_BIG];
    bit          model_known [c_BIG];
    logic [31:0] model_s [c_SMALL];
    logic [31:0] stream [$];

    riscv_mem_responder_if #(.ADDR_WIDTH(32)) bus ();
    riscv_mem_responder_if #(.ADDR_WIDTH(32)) bus_s ();

    riscv_mem_responder #(.MEM_WORDS(c_BIG), .ADDR_WIDTH(32),
        .TOHOST_ADDR(c_TOHOST), .NOP_INSN(c_NOP))
        dut (.clk(clk), .resetn(resetn), .bus(bus));

    riscv_mem_responder #(.MEM_WORDS(c_SMALL), .ADDR_WIDTH(32),
        .TOHOST_ADDR(c_TOHOST), .NOP_INSN(c_NOP))
        dut_s (.clk(clk), .resetn(resetn_s), .bus(bus_s));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.InstrAdr = 32'h0; bus.memAdr = 32'h0; bus.memwrData = 32'h0;
        bus.memWE = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = 32'h0; bus.ld_last = 1'b0;
        bus_s.InstrAdr = 32'h0; bus_s.memAdr = 32'h0; bus_s.memwrData = 32'h0;
        bus_s.memWE = 1'b0; bus_s.ld_valid = 1'b0; bus_s.ld_data = 32'h0; bus_s.ld_last = 1'b0;
    endtask

    // Streams the queue into the large instance; model pointer restarts at 0 after reset.
    task automatic load_big(input bit gaps, input bit with_last, input bit hold_we);
        int idx = 0;
        int ptr = 0;
        bit hs;
        for (int cyc = 0; cyc < 4000 && idx < stream.size(); cyc++) begin
            bus.ld_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.ld_data   = stream[idx];
            bus.ld_last   = with_last && (idx == stream.size() - 1);
            bus.memWE     = hold_we && (idx != stream.size() - 1);
            bus.memAdr    = 32'h0;
            bus.memwrData = 32'hFFFF_FFFF;
            bus.InstrAdr  = $urandom;
            #1;
            vectors++;
            if (bus.InstrData !== c_NOP || bus.ld_ready !== 1'b1 || bus.core_resetn !== 1'b0) begin
                miscompares++;
                $display("FAIL load_cycle: InstrData=%h ld_ready=%b core_resetn=%b, required %h/1/0",
                         bus.InstrData, bus.ld_ready, bus.core_resetn, c_NOP);
            end
            hs = bus.ld_valid;
            tick;
            if (hs) begin
                model_mem[ptr] = stream[idx];
                model_known[ptr] = 1'b1;
                ptr++;
                idx++;
            end
        end
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0; bus.memWE = 1'b0; bus.InstrAdr = 32'h0;
        #1;
        vectors++;
        if (idx != stream.size() || bus.core_resetn !== with_last || bus.ld_ready !== !with_last) begin
            miscompares++;
            $display("FAIL load_end: words=%0d/%0d core_resetn=%b ld_ready=%b, required %b/%b",
                     idx, stream.size(), bus.core_resetn, bus.ld_ready, with_last, !with_last);
        end
    endtask

    task automatic check_loaded_words(input int n);
        for (int i = 0; i < n; i++) begin
            bus.memAdr = 32'(i * 4);
            bus.InstrAdr = 32'(i * 4);
            #1;
            vectors++;
            if (bus.memrdData !== model_mem[i] || bus.InstrData !== model_mem[i]) begin
                miscompares++;
                $display("FAIL loaded_word[%0d]: memrd=%h instr=%h, required %h",
                         i, bus.memrdData, bus.InstrData, model_mem[i]);
            end
        end
        bus.memAdr = 32'h0; bus.InstrAdr = 32'h0;
    endtask

    task automatic test_reset;
        resetn = 1'b0; resetn_s = 1'b0;
        idle_inputs();
        tick; tick;
        vectors++;
        if (bus.ld_ready !== 1'b0 || bus.core_resetn !== 1'b0 || bus.halted !== 1'b0 ||
            bus.tohost !== 32'h0 || bus.ld_overflow !== 1'b0 || bus.addr_err !== 1'b0 ||
            bus.InstrData !== c_NOP) begin
            miscompares++;
            $display("FAIL reset_state: rdy=%b cr=%b h=%b th=%h ovf=%b err=%b instr=%h, required 0/0/0/0/0/0/%h",
                     bus.ld_ready, bus.core_resetn, bus.halted, bus.tohost, bus.ld_overflow,
                     bus.addr_err, bus.InstrData, c_NOP);
        end
        resetn = 1'b1;
        #1;
        vectors++;
        if (bus.ld_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_release_cycle: ld_ready=%b, required 0", bus.ld_ready);
        end
        tick;
        vectors++;
        if (bus.ld_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_release: ld_ready=%b, required 1", bus.ld_ready);
        end
    endtask

    task automatic test_load_basic;
        stream = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h0000_0013};
        load_big(1'b0, 1'b1, 1'b1);
        bus.InstrAdr = 32'd8;
        #1;
        vectors++;
        if (bus.InstrData !== 32'h0020_81B3) begin
            miscompares++;
            $display("FAIL fetch_addr8: InstrData=%h, required 002081b3", bus.InstrData);
        end
        check_loaded_words(4);
    endtask

    task automatic test_gap_load;
        int n;
        resetn = 1'b0; tick; resetn = 1'b1; tick;
        stream.delete();
        for (int i = 0; i < 3; i++) stream.push_back($urandom);
        load_big(1'b1, 1'b0, 1'b0);
        // Abort mid-load: the next image must start again at word 0.
        resetn = 1'b0; tick; resetn = 1'b1; tick;
        stream.delete();
        n = $urandom_range(5, 12);
        for (int i = 0; i < n; i++) stream.push_back($urandom);
        load_big(1'b1, 1'b1, 1'b0);
        check_loaded_words(n);
    endtask

    task automatic test_store_forward;
        logic [31:0] v0;
        v0 = $urandom;
        bus.memWE = 1'b1; bus.memAdr = 32'h20; bus.memwrData = v0;
        tick;
        model_mem[8] = v0; model_known[8] = 1'b1;
        bus.memwrData = 32'hDEAD_BEEF; bus.InstrAdr = 32'h20;
        #1;
        vectors++;
        if (bus.InstrData !== v0 || bus.memrdData !== v0) begin
            miscompares++;
            $display("FAIL same_cycle_old: instr=%h memrd=%h, required %h", bus.InstrData, bus.memrdData, v0);
        end
        tick;
        model_mem[8] = 32'hDEAD_BEEF;
        bus.memWE = 1'b0; bus.memAdr = 32'h22;
        #1;
        vectors++;
        if (bus.InstrData !== 32'hDEAD_BEEF || bus.memrdData !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL store_visible: instr=%h memrd@22=%h, required deadbeef", bus.InstrData, bus.memrdData);
        end
    endtask

    task automatic test_random_run;
        int          d_idx;
        int          i_idx;
        bit          st;
        logic [31:0] wd;
        for (int it = 0; it < 200; it++) begin
            d_idx = $urandom_range(0, 63);
            i_idx = $urandom_range(0, 63);
            st = ($urandom_range(0, 1) == 1);
            wd = $urandom;
            bus.memAdr = 32'(d_idx * 4) | 32'($urandom_range(0, 3));
            bus.InstrAdr = 32'(i_idx * 4) | 32'($urandom_range(0, 3));
            bus.memWE = st; bus.memwrData = wd;
            #1;
            if (model_known[d_idx]) begin
                vectors++;
                if (bus.memrdData !== model_mem[d_idx]) begin
                    miscompares++;
                    $display("FAIL rand_load[%0d]: memrd=%h, required %h", d_idx, bus.memrdData, model_mem[d_idx]);
                end
            end
            if (model_known[i_idx]) begin
                vectors++;
                if (bus.InstrData !== model_mem[i_idx]) begin
                    miscompares++;
                    $display("FAIL rand_fetch[%0d]: instr=%h, required %h", i_idx, bus.InstrData, model_mem[i_idx]);
                end
            end
            tick;
            if (st) begin
                model_mem[d_idx] = wd;
                model_known[d_idx] = 1'b1;
            end
        end
        bus.memWE = 1'b0; bus.memAdr = 32'h0;
        #1;
        vectors++;
        if (bus.addr_err !== 1'b0 || bus.halted !== 1'b0) begin
            miscompares++;
            $display("FAIL run_flags_quiet: addr_err=%b halted=%b, required 0/0", bus.addr_err, bus.halted);
        end
    endtask

    task automatic test_addr_err;
        bus.memWE = 1'b1; bus.memAdr = 32'h2000; bus.memwrData = $urandom;
        bus.InstrAdr = 32'h2000;
        #1;
        vectors++;
        if (bus.memrdData !== 32'h0 || bus.InstrData !== 32'h0) begin
            miscompares++;
            $display("FAIL oob_read_zero: memrd=%h instr=%h, required 0/0", bus.memrdData, bus.InstrData);
        end
        tick;
        bus.memWE = 1'b0;
        #1;
        vectors++;
        if (bus.addr_err !== 1'b1 || bus.memrdData !== 32'h0 || bus.halted !== 1'b0) begin
            miscompares++;
            $display("FAIL addr_err_set: err=%b memrd@2000=%h halted=%b, required 1/0/0",
                     bus.addr_err, bus.memrdData, bus.halted);
        end
        // 0x2000 aliases word 0 if upper address bits were ignored.
        bus.memAdr = 32'h0; bus.InstrAdr = 32'h0;
        tick;
        vectors++;
        if (bus.memrdData !== model_mem[0] || bus.addr_err !== 1'b1) begin
            miscompares++;
            $display("FAIL oob_no_write: word0=%h err=%b, required %h/1", bus.memrdData, bus.addr_err, model_mem[0]);
        end
    endtask

    task automatic test_tohost;
        bus.memWE = 1'b1; bus.memAdr = 32'h40; bus.memwrData = 32'h1234_5678;
        tick;
        model_mem[16] = 32'h1234_5678;
        bus.memAdr = c_TOHOST; bus.memwrData = 32'h1;
        #1;
        vectors++;
        if (bus.halted !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_early: halted=%b, required 0", bus.halted);
        end
        tick;
        bus.memWE = 1'b0;
        #1;
        vectors++;
        if (bus.halted !== 1'b1 || bus.tohost !== 32'h1 || bus.memrdData !== 32'h1 || bus.core_resetn !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_latch: halted=%b tohost=%h memrd=%h cr=%b, required 1/1/1/1",
                     bus.halted, bus.tohost, bus.memrdData, bus.core_resetn);
        end
        bus.memWE = 1'b1; bus.memAdr = 32'h40; bus.memwrData = 32'h55;
        tick;
        bus.memAdr = c_TOHOST; bus.memwrData = 32'h7;
        tick;
        bus.memWE = 1'b0; bus.memAdr = 32'h40; bus.InstrAdr = 32'h40; bus.ld_valid = 1'b1;
        #1;
        vectors++;
        if (bus.memrdData !== 32'h1234_5678 || bus.InstrData !== 32'h1234_5678 ||
            bus.tohost !== 32'h1 || bus.halted !== 1'b1 || bus.ld_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_ignores_writes: memrd=%h instr=%h tohost=%h halted=%b rdy=%b, required 12345678/12345678/1/1/0",
                     bus.memrdData, bus.InstrData, bus.tohost, bus.halted, bus.ld_ready);
        end
        bus.ld_valid = 1'b0;
    endtask

    task automatic test_overflow;
        int idx = 0;
        resetn_s = 1'b0; tick; resetn_s = 1'b1; tick;
        for (int i = 0; i < 6; i++) begin
            bus_s.ld_valid = 1'b1;
            bus_s.ld_data = $urandom;
            bus_s.ld_last = (i == 5);
            #1;
            vectors++;
            if (bus_s.ld_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL small_ready[%0d]: ld_ready=%b, required 1", i, bus_s.ld_ready);
            end
            if (i < c_SMALL) model_s[i] = bus_s.ld_data;
            tick;
            idx++;
        end
        bus_s.ld_valid = 1'b0; bus_s.ld_last = 1'b0;
        #1;
        vectors++;
        if (bus_s.ld_overflow !== 1'b1 || bus_s.core_resetn !== 1'b1 || bus_s.addr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_run: ovf=%b cr=%b err=%b, required 1/1/0",
                     bus_s.ld_overflow, bus_s.core_resetn, bus_s.addr_err);
        end
        for (int i = 0; i < c_SMALL; i++) begin
            bus_s.memAdr = 32'(i * 4); bus_s.InstrAdr = 32'(i * 4);
            #1;
            vectors++;
            if (bus_s.memrdData !== model_s[i] || bus_s.InstrData !== model_s[i]) begin
                miscompares++;
                $display("FAIL small_word[%0d]: memrd=%h instr=%h, required %h",
                         i, bus_s.memrdData, bus_s.InstrData, model_s[i]);
            end
        end
        bus_s.memAdr = 32'h0; bus_s.InstrAdr = 32'h0;
        resetn_s = 1'b0; tick; resetn_s = 1'b1;
        #1;
        vectors++;
        if (bus_s.core_resetn !== 1'b0 || bus_s.ld_overflow !== 1'b0 || bus_s.ld_ready !== 1'b0 ||
            bus_s.InstrData !== c_NOP || bus_s.memrdData !== model_s[0]) begin
            miscompares++;
            $display("FAIL small_rereset: cr=%b ovf=%b rdy=%b instr=%h word0=%h, required 0/0/0/%h/%h",
                     bus_s.core_resetn, bus_s.ld_overflow, bus_s.ld_ready, bus_s.InstrData,
                     bus_s.memrdData, c_NOP, model_s[0]);
        end
        tick;
        vectors++;
        if (bus_s.ld_ready !== 1'b1 || idx != 6) begin
            miscompares++;
            $display("FAIL small_reload_ready: ld_ready=%b, required 1", bus_s.ld_ready);
        end
    endtask

    initial begin
        for (int i = 0; i < c_BIG; i++) model_known[i] = 1'b0;
        test_reset();
        test_load_basic();
        test_gap_load();
        test_store_forward();
        test_random_run();
        test_addr_err();
        test_tohost();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
